// File: rtl/dca_lsu_txn_pkg.sv
// Shared definitions for the LSU transaction lookahead mux.
// Holds the per-channel state encoding and helpers that derive field widths
// and bit offsets of the input transaction and output (tagged) transaction.
//   txn     layout (MSB..LSB): {last, term, len, addr}
//   out_txn layout (MSB..LSB): {tag, term, len, addr, ch_id}
package dca_lsu_txn_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_HELD  = 1'b1
    } ch_state_e;

    function automatic int txn_bw(input int bw_addr, input int bw_len);
        return bw_addr + bw_len + 2;
    endfunction

    function automatic int ch_bw(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int out_bw(input int bw_addr, input int bw_len, input int num_ch);
        return txn_bw(bw_addr, bw_len) + ch_bw(num_ch);
    endfunction

    // Input transaction field offsets (addr starts at bit 0).
    function automatic int txn_len_lsb(input int bw_addr);
        return bw_addr;
    endfunction

    function automatic int txn_term_bit(input int bw_addr, input int bw_len);
        return bw_addr + bw_len;
    endfunction

    function automatic int txn_last_bit(input int bw_addr, input int bw_len);
        return bw_addr + bw_len + 1;
    endfunction

    // Output transaction field offsets (ch_id starts at bit 0).
    function automatic int out_addr_lsb(input int bw_ch);
        return bw_ch;
    endfunction

    function automatic int out_tag_bit(input int bw_ch, input int bw_addr, input int bw_len);
        return bw_ch + bw_addr + bw_len + 1;
    endfunction

endpackage

// File: rtl/dca_lsu_tag_fifo.sv
// Registered synchronous FIFO for tagged transactions.
// Ports:
//   clk, rstp    - clock, synchronous active-high reset
//   enable       - 0 freezes push, pop and pointers
//   clear        - synchronous empty (discards contents)
//   wvalid/wdata - push request / data; wready = not full
//   rvalid/rdata - head valid / head data (0 when empty)
//   rready       - pop head
//   num          - occupancy
// No write-to-read bypass: a push becomes visible the following cycle, and a
// pop does not make room for a push in the same cycle (wready ignores rready).
module dca_lsu_tag_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int NW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstp,
    input  logic          enable,
    input  logic          clear,
    input  logic          wvalid,
    input  logic [W-1:0]  wdata,
    output logic          wready,
    output logic          rvalid,
    output logic [W-1:0]  rdata,
    input  logic          rready,
    output logic [NW-1:0] num
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic [AW:0]  count;
    logic         push;
    logic         pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count  = wptr_q - rptr_q;
    assign num    = NW'(count);
    assign wready = (count != FULL_CNT);
    assign rvalid = (count != '0);
    assign rdata  = rvalid ? mem[rptr_q[AW-1:0]] : '0;

    assign push = wvalid & wready & enable & ~clear & ~rstp;
    assign pop  = rvalid & rready & enable & ~clear & ~rstp;

    always_ff @(posedge clk) begin
        if (rstp || clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage is deliberately not reset; the empty head is masked instead.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dca_lsu_txn_lookahead_mux.sv
// Multi-channel LSU transaction lookahead tagger and round-robin mux.
// Each channel holds one transaction; it is emitted tagged with the successor's
// last bit, 0 if it is itself terminal, or FLUSH_TAG on an explicit flush.
// Ports:
//   clk, rstp            - clock, synchronous active-high reset
//   enable               - 0 freezes all state (no accept/push/pop)
//   clear                - synchronous flush of held registers and FIFO
//   in_valid/in_ready    - per-channel request handshake
//   in_txn               - per-channel {last, term, len, addr}, channel c in slice c
//   flush                - per-channel forced emission of the held transaction
//   held                 - per-channel lookahead register occupied (channel state)
//   out_valid/out_ready  - FIFO head handshake
//   out_txn              - {tag, term, len, addr, ch_id} at FIFO head
//   out_num              - FIFO occupancy
// Handshake: a transfer happens on a clock edge where valid & ready are both 1
// (and enable=1); ready may depend combinationally on valid-side inputs, and a
// source keeps its payload stable until it is accepted.
module dca_lsu_txn_lookahead_mux
    import dca_lsu_txn_pkg::*;
#(
    parameter  int   NUM_CH    = 2,
    parameter  int   BW_ADDR   = 32,
    parameter  int   BW_LEN    = 8,
    parameter  int   DEPTH     = 4,
    parameter  logic FLUSH_TAG = 1'b1,
    localparam int   BW_TXN    = txn_bw(BW_ADDR, BW_LEN),
    localparam int   BW_CH     = ch_bw(NUM_CH),
    localparam int   BW_OUT    = out_bw(BW_ADDR, BW_LEN, NUM_CH),
    localparam int   BW_NUM    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rstp,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*BW_TXN-1:0] in_txn,
    input  logic [NUM_CH-1:0]        flush,
    output logic [NUM_CH-1:0]        held,
    output logic                     out_valid,
    output logic [BW_OUT-1:0]        out_txn,
    input  logic                     out_ready,
    output logic [BW_NUM-1:0]        out_num
);

    localparam int TXN_LEN_LSB  = txn_len_lsb(BW_ADDR);
    localparam int TXN_TERM_BIT = txn_term_bit(BW_ADDR, BW_LEN);
    localparam int TXN_LAST_BIT = txn_last_bit(BW_ADDR, BW_LEN);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [BW_OUT-1:0] cand [NUM_CH];
    logic [BW_CH-1:0]  ptr_q;
    logic [BW_CH-1:0]  gidx;
    logic              any_grant;
    logic              can_grant;
    logic              fifo_wready;

    // Grants need FIFO space as seen at the start of the cycle; clear wins
    // over any push so in-flight data is discarded.
    assign can_grant = enable & ~clear & ~rstp & fifo_wready;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            ch_state_e           state_q;
            logic                h_term;
            logic [BW_LEN-1:0]   h_len;
            logic [BW_ADDR-1:0]  h_addr;
            logic [BW_TXN-1:0]   txn;
            logic                accept;

            assign txn     = in_txn[c*BW_TXN +: BW_TXN];
            assign held[c] = (state_q == CH_HELD);

            // First match wins: own terminal status, then successor, then flush.
            assign req[c] = held[c] & (h_term | in_valid[c] | flush[c]);
            assign cand[c] = {
                h_term ? 1'b0 : (in_valid[c] ? txn[TXN_LAST_BIT] : FLUSH_TAG),
                h_term, h_len, h_addr, BW_CH'(c)
            };

            // A held channel can only take a new transaction in the cycle its
            // current one leaves (simultaneous push and accept).
            assign in_ready[c] = enable & ~clear & ~rstp & (~held[c] | grant[c]);
            assign accept      = in_valid[c] & in_ready[c];

            always_ff @(posedge clk) begin
                if (rstp || clear) begin
                    state_q <= CH_EMPTY;
                    h_term  <= 1'b0;
                    h_len   <= '0;
                    h_addr  <= '0;
                end else if (accept) begin
                    // The incoming last bit is consumed as the predecessor's tag.
                    state_q <= CH_HELD;
                    h_term  <= txn[TXN_TERM_BIT];
                    h_len   <= txn[TXN_LEN_LSB +: BW_LEN];
                    h_addr  <= txn[BW_ADDR-1:0];
                end else if (grant[c]) begin
                    state_q <= CH_EMPTY;
                end
            end
        end
    endgenerate

    // Round-robin: search starts at ptr_q, first requester found wins.
    always_comb begin
        int idx;
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (!any_grant && can_grant && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = BW_CH'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstp || clear) begin
            ptr_q <= '0;
        end else if (any_grant) begin
            ptr_q <= (gidx == BW_CH'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
        end
    end

    dca_lsu_tag_fifo #(
        .W     (BW_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstp   (rstp),
        .enable (enable),
        .clear  (clear),
        .wvalid (any_grant),
        .wdata  (cand[gidx]),
        .wready (fifo_wready),
        .rvalid (out_valid),
        .rdata  (out_txn),
        .rready (out_ready),
        .num    (out_num)
    );

endmodule

// File: tb/tb_dca_lsu_txn_lookahead_mux.sv
module tb_dca_lsu_txn_lookahead_mux;

    localparam int   NUM_CH    = 2;
    localparam int   BW_ADDR   = 32;
    localparam int   BW_LEN    = 8;
    localparam int   DEPTH     = 4;
    localparam logic FLUSH_TAG = 1'b1;
    localparam int   BW_TXN    = BW_ADDR + BW_LEN + 2;
    localparam int   BW_CH     = 1;
    localparam int   BW_OUT    = BW_TXN + BW_CH;
    localparam int   BW_NUM    = $clog2(DEPTH + 1);

    // ---------------- clock / reset / DUT ----------------
    logic                     clk;
    logic                     rstp;
    logic                     enable;
    logic                     clear;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*BW_TXN-1:0] in_txn;
    logic [NUM_CH-1:0]        flush;
    logic [NUM_CH-1:0]        held;
    logic                     out_valid;
    logic [BW_OUT-1:0]        out_txn;
    logic                     out_ready;
    logic [BW_NUM-1:0]        out_num;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dca_lsu_txn_lookahead_mux #(
        .NUM_CH    (NUM_CH),
        .BW_ADDR   (BW_ADDR),
        .BW_LEN    (BW_LEN),
        .DEPTH     (DEPTH),
        .FLUSH_TAG (FLUSH_TAG)
    ) dut (
        .clk       (clk),
        .rstp      (rstp),
        .enable    (enable),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_txn    (in_txn),
        .flush     (flush),
        .held      (held),
        .out_valid (out_valid),
        .out_txn   (out_txn),
        .out_ready (out_ready),
        .out_num   (out_num)
    );

    // ---------------- scoreboard state ----------------
    logic [BW_OUT-1:0] exp_q[$];
    logic [BW_TXN-1:0] it0 [8];
    logic [BW_TXN-1:0] it1 [8];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW_TXN-1:0] mk_txn(input logic last, input logic term,
                                                 input logic [BW_LEN-1:0] len,
                                                 input logic [BW_ADDR-1:0] addr);
        return {last, term, len, addr};
    endfunction

    function automatic logic [BW_OUT-1:0] mk_out(input logic tag, input logic term,
                                                 input logic [BW_LEN-1:0] len,
                                                 input logic [BW_ADDR-1:0] addr,
                                                 input logic [BW_CH-1:0] ch);
        return {tag, term, len, addr, ch};
    endfunction

    // Every FIFO pop is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rstp && !clear && enable && out_valid && out_ready) begin
            check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("sb_pop", 64'(out_txn), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents it0[0..n0-1] / it1[0..n1-1], each held until accepted.
    task automatic drive_streams(input int n0, input int n1);
        int i0 = 0;
        int i1 = 0;
        bit done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            next_cycle();
            in_valid[0] = (i0 < n0);
            in_valid[1] = (i1 < n1);
            if (i0 < n0) in_txn[0 +: BW_TXN] = it0[i0];
            if (i1 < n1) in_txn[BW_TXN +: BW_TXN] = it1[i1];
            #1;
            if (in_valid[0] && in_ready[0]) i0++;
            if (in_valid[1] && in_ready[1]) i1++;
            done = (i0 == n0) && (i1 == n1);
        end
        check("streams_accepted", 64'(done), 64'd1);
        next_cycle();
        in_valid = '0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_num != 0; k++) next_cycle();
        check("drain_empty", 64'(out_num), 64'd0);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BW_LEN-1:0]  l0, l1;
        logic [BW_ADDR-1:0] a0, a1;

        rstp = 1'b1; enable = 1'b1; clear = 1'b0;
        in_valid = '0; in_txn = '0; flush = '0; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        check("rst_held",      64'(held),      64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_num",   64'(out_num),   64'd0);
        check("rst_out_txn",   64'(out_txn),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        next_cycle();
        rstp = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'h3);

        // Single terminal transaction on channel 0: visible two cycles later.
        it0[0] = mk_txn(1'b0, 1'b1, 8'd3, 32'h100);
        exp_q.push_back(mk_out(1'b0, 1'b1, 8'd3, 32'h100, 1'b0));
        drive_streams(1, 0);
        check("t1_held",       64'(held),      64'h1);
        check("t1_valid_early",64'(out_valid), 64'd0);
        next_cycle();
        check("t1_out_valid",  64'(out_valid), 64'd1);
        check("t1_out_num",    64'(out_num),   64'd1);
        check("t1_out_txn",    64'(out_txn),   64'(mk_out(1'b0, 1'b1, 8'd3, 32'h100, 1'b0)));
        drain();

        // Flush together with a successor: successor's last (0) is the tag.
        it0[0] = mk_txn(1'b0, 1'b0, 8'd7, 32'h300);
        it0[1] = mk_txn(1'b0, 1'b0, 8'd9, 32'h340);
        exp_q.push_back(mk_out(1'b0, 1'b0, 8'd7, 32'h300, 1'b0));
        flush = 2'b01;
        drive_streams(2, 0);
        flush = 2'b00;
        check("fv_held",    64'(held),    64'h1);
        check("fv_out_num", 64'(out_num), 64'd1);
        next_cycle();
        flush = 2'b01;
        exp_q.push_back(mk_out(FLUSH_TAG, 1'b0, 8'd9, 32'h340, 1'b0));
        next_cycle();
        flush = 2'b00;
        check("fv_flushed_held", 64'(held), 64'd0);
        drain();

        // Lookahead: A tagged with B.last, B waits for flush.
        it1[0] = mk_txn(1'b0, 1'b0, 8'd2, 32'h200);
        it1[1] = mk_txn(1'b1, 1'b0, 8'd4, 32'h240);
        exp_q.push_back(mk_out(1'b1, 1'b0, 8'd2, 32'h200, 1'b1));
        drive_streams(0, 2);
        check("la_held",    64'(held),    64'h2);
        check("la_out_num", 64'(out_num), 64'd1);
        next_cycle();
        next_cycle();
        check("la_b_still_held", 64'(held), 64'h2);
        drain();
        next_cycle();
        flush = 2'b10;
        exp_q.push_back(mk_out(FLUSH_TAG, 1'b0, 8'd4, 32'h240, 1'b1));
        next_cycle();
        flush = 2'b00;
        check("la_flush_held", 64'(held),    64'd0);
        check("la_flush_num",  64'(out_num), 64'd1);
        drain();

        // Arbitration: both channels always busy -> strict alternation 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            l0 = 8'($urandom_range(0, 255));
            l1 = 8'($urandom_range(0, 255));
            a0 = 32'($urandom_range(0, 32'h0fff_ffff));
            a1 = 32'($urandom_range(0, 32'h0fff_ffff));
            it0[k] = mk_txn(1'($urandom_range(0, 1)), 1'b1, l0, a0);
            it1[k] = mk_txn(1'($urandom_range(0, 1)), 1'b1, l1, a1);
            exp_q.push_back(mk_out(1'b0, 1'b1, l0, a0, 1'b0));
            exp_q.push_back(mk_out(1'b0, 1'b1, l1, a1, 1'b1));
        end
        out_ready = 1'b1;
        drive_streams(4, 4);
        drain();

        // Backpressure: FIFO fills, 5th transaction stays held.
        for (int k = 0; k < 5; k++) begin
            it0[k] = mk_txn(1'b0, 1'b1, 8'(k + 1), 32'h400 + 32'(16 * k));
            exp_q.push_back(mk_out(1'b0, 1'b1, 8'(k + 1), 32'h400 + 32'(16 * k), 1'b0));
        end
        drive_streams(5, 0);
        check("bp_num_full", 64'(out_num), 64'd4);
        check("bp_held",     64'(held),    64'h1);
        #1;
        check("bp_in_ready", 64'(in_ready[0]), 64'd0);
        next_cycle();
        check("bp_num_sat", 64'(out_num), 64'd4);
        out_ready = 1'b1;
        #1;
        check("bp_pop_no_room", 64'(in_ready[0]), 64'd0);
        next_cycle();
        out_ready = 1'b0;
        check("bp_after_pop_num",  64'(out_num), 64'd3);
        check("bp_after_pop_held", 64'(held),    64'h1);
        #1;
        check("bp_grant_ready", 64'(in_ready[0]), 64'd1);
        next_cycle();
        check("bp_refill_num",  64'(out_num), 64'd4);
        check("bp_refill_held", 64'(held),    64'd0);
        drain();

        // clear with 2 FIFO entries and both channels held.
        it0[0] = mk_txn(1'b0, 1'b0, 8'd1, 32'h500);
        it0[1] = mk_txn(1'b0, 1'b0, 8'd1, 32'h510);
        it1[0] = mk_txn(1'b0, 1'b0, 8'd1, 32'h580);
        it1[1] = mk_txn(1'b0, 1'b0, 8'd1, 32'h590);
        drive_streams(2, 2);
        check("clr_pre_num",  64'(out_num), 64'd2);
        check("clr_pre_held", 64'(held),    64'h3);
        clear = 1'b1;
        #1;
        check("clr_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        clear = 1'b0;
        check("clr_num",       64'(out_num),   64'd0);
        check("clr_held",      64'(held),      64'd0);
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_out_txn",   64'(out_txn),   64'd0);
        next_cycle();
        next_cycle();
        check("clr_no_push", 64'(out_num), 64'd0);

        // enable=0 for 3 cycles with traffic on every input.
        it0[0] = mk_txn(1'b0, 1'b1, 8'd5, 32'h600);
        it1[0] = mk_txn(1'b0, 1'b0, 8'd6, 32'h700);
        exp_q.push_back(mk_out(1'b0, 1'b1, 8'd5, 32'h600, 1'b0));
        drive_streams(1, 1);
        next_cycle();
        check("en_pre_num", 64'(out_num), 64'd1);
        enable = 1'b0;
        in_valid = 2'b11;
        flush = 2'b11;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("en_in_ready", 64'(in_ready), 64'd0);
            next_cycle();
            check("en_num",  64'(out_num), 64'd1);
            check("en_held", 64'(held),    64'h2);
            check("en_txn",  64'(out_txn), 64'(mk_out(1'b0, 1'b1, 8'd5, 32'h600, 1'b0)));
        end
        enable = 1'b1;
        in_valid = '0;
        flush = 2'b10;
        out_ready = 1'b0;
        exp_q.push_back(mk_out(FLUSH_TAG, 1'b0, 8'd6, 32'h700, 1'b1));
        next_cycle();
        flush = '0;
        check("en_resume_num",  64'(out_num), 64'd2);
        check("en_resume_held", 64'(held),    64'd0);
        drain();

        next_cycle();
        next_cycle();
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dca_lsu_txn_lookahead_mux.md
# dca_lsu_txn_lookahead_mux

Multi-channel successor to the single-channel LSU transaction tagger. Each of NUM_CH load/store request streams holds one transaction in a one-entry lookahead register. A held transaction is tagged with its successor's last flag, with its own terminal status, or with an explicit flush. A round-robin arbiter then pushes it, with its channel id, into a shared output FIFO feeding the matrix LSU AXI issue stage.

## Interface
Parameters:
- NUM_CH, 2: number of input channels (1..8).
- BW_ADDR, 32: bit-address field width.
- BW_LEN, 8: burst-length field width (AXI alen).
- DEPTH, 4: output FIFO depth (power of two, ≥2).
- FLUSH_TAG, 1: tag value written when a held transaction leaves through flush.
- Derived: BW_TXN = BW_ADDR+BW_LEN+2; BW_CH = max(1,clog2(NUM_CH)); BW_OUT = BW_TXN+BW_CH.

Ports:
- clk, input, 1: clock.
- rstp, input, 1: reset. One clock; reset is synchronous and active-high.
- enable, input, 1: global advance; 0 freezes all state.
- clear, input, 1: synchronous flush of held registers and FIFO.
- in_valid, input, NUM_CH: per-channel request valid.
- in_ready, output, NUM_CH: per-channel accept.
- in_txn, input, NUM_CH*BW_TXN: per channel {last, term, len, addr}, where channel c occupies slice c.
- flush, input, NUM_CH: force emission of the held transaction.
- held, output, NUM_CH: channel lookahead register occupied.
- out_valid, output, 1: FIFO non-empty.
- out_txn, output, BW_OUT: {tag, term, len, addr, ch_id} at FIFO head.
- out_ready, input, 1: pop FIFO head.
- out_num, output, clog2(DEPTH+1): FIFO occupancy.

## Operation
- Each channel has two states:
  - EMPTY: nothing held.
  - HELD: holds register h = {term, len, addr} and discards the incoming last bit.
- Emission request in HELD, first match wins:
  - h.term=1: request with tag=0.
  - in_valid=1: request with tag=in_txn.last.
  - flush=1: request with tag=FLUSH_TAG.
  - Otherwise no request.
- Arbiter: round-robin among requesting channels, granting at most one channel per cycle. A grant is issued only when the FIFO is not full and enable=1. The pointer advances to the channel after the granted one. It resets to channel 0.
- Grant pushes {tag, h.term, h.len, h.addr, c} into the FIFO.
- Input acceptance: in_ready[c] = enable & ~clear & (EMPTY | grant[c]).
- Transitions:
  - EMPTY with accept: go to HELD and load in_txn.
  - HELD with grant and in_valid: stay HELD and load the new in_txn. This is a simultaneous push and accept.
  - HELD with grant and no in_valid: go to EMPTY.
  - HELD without grant: stay HELD and hold h.
- The FIFO pops when out_valid & out_ready & enable.
- Priority order is rstp > clear > enable.
  - rstp or clear: all channels go to EMPTY, the FIFO empties, and the pointer resets to 0.
  - clear discards in-flight data without pushing it.
- enable=0: no accept, push, pop, or pointer movement. Outputs still reflect current state.

## Timing
- Reset values:
  - in_ready = all 0 while rstp=1. It is all 1 on the first cycle after reset if enable=1.
  - held=0, out_valid=0, out_num=0.
  - out_txn = 0 (FIFO storage is not reset; the head is forced to 0 when empty).
- Latency: a term transaction accepted in cycle N is HELD at N+1, granted at N+1, and shows out_valid at N+2 when uncontended.
- A non-term transaction waits for a successor or flush. Its push occurs in the cycle the successor is accepted.
- The FIFO is registered with no write-to-read bypass. A push in cycle N is visible at N+1.
- FIFO full: no grants.
  - HELD channels see in_ready=0.
  - EMPTY channels still accept.
  - A pop in the same cycle does not free space for that cycle's grant.
- FIFO empty with out_ready=1: no pop, and out_num stays 0.
- Same-cycle flush and in_valid: in_valid wins and the tag comes from in_txn.last.
- Throughput: 1 transaction per cycle aggregate. With NUM_CH contending streams each gets ≥1/NUM_CH.

## Structure
- Package dca_lsu_txn_pkg holds:
  - field offsets and widths of the txn and out_txn layouts;
  - the EMPTY/HELD state encoding;
  - a helper function computing BW_OUT.
- Sub-module dca_lsu_tag_fifo: synchronous FIFO with rstp/enable/clear, exposing wready, rvalid and num.
- The channel registers and arbiter are implemented in this module, with one generate loop over NUM_CH.

## Test plan
- Single term transaction: channel 0 sends {last=0, term=1, len=3, addr=0x100}. Required: out_valid 2 cycles later with out_txn {tag=0, term=1, len=3, addr=0x100, ch=0}.
- Lookahead tagging: channel 1 sends A {term=0, addr=0x200}, then B {last=1, term=0, addr=0x240}. Required: A pops with tag=1. B stays held with held[1]=1 until flush[1] is pulsed, then pops with tag=FLUSH_TAG.
- Arbitration: both channels hold term transactions every cycle. Required: pushes alternate ch 0,1,0,1 and no channel is granted twice in a row.
- Backpressure: DEPTH=4 with out_ready=0 and 5 term transactions on channel 0. Required: out_num saturates at 4, the 5th stays held and in_ready[0]=0. Draining one entry lets it push the next cycle.
- clear mid-stream: 2 entries in the FIFO and both channels HELD, then pulse clear. Required: the next cycle has out_num=0, held=0 and out_valid=0, and nothing is pushed.
- enable=0 for 3 cycles during traffic. Required: out_num, held and out_txn do not change, and in_ready=0.
